imem_loader: RTL
================

# imem_loader

Instruction-memory owner on the fetch side of the ARM pipeline: it accepts a word stream from a boot/host writer, fills a word-addressed instruction RAM, then serves the fetch stage's combinational PC-indexed reads. It holds the pipeline frozen through `fetch_stall` while loading, so the fetch stage never executes a partially written program. A `reload` request returns it to loading at any time.

## Interface
- `DEPTH`, 64: instruction words held; power of two, 2..1024.
- `NOP_WORD`, 32'hE000_0000: fill value and out-of-range read value (AL-condition AND R0,R0,R0).
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high; clock clk.
- `reload`  in  1  single-cycle request to restart loading.
- `load_valid`  in  1  writer has a word on `load_data`.
- `load_ready`  out  1  block accepts a word this cycle.
- `load_data`  in  32  instruction word, or checksum beat (see Configuration).
- `load_last`  in  1  marks the final instruction word of the stream.
- `fetch_addr`  in  32  byte address from the fetch stage's PC register.
- `fetch_inst`  out  32  instruction at `fetch_addr`.
- `fetch_stall`  out  1  freeze request to fetch and the pipeline.
- `loaded_words`  out  log2(DEPTH)+1  words written in the last or current load.
- `err`  out  1  checksum mismatch flag.

## Operation
- Word index = `fetch_addr[log2(DEPTH)+1:2]`. Bits [1:0] are ignored. `fetch_addr >= DEPTH*4` returns `NOP_WORD`.
- States: LOAD, CHECK (only when the macro is defined), RUN, ERR.
- Reset: state LOAD, write pointer 0, `loaded_words`=0, `err`=0, every array word = `NOP_WORD`.
- `load_ready` = (state==LOAD) or (state==CHECK). `fetch_stall` = (state!=RUN).
- LOAD: on `load_valid`&&`load_ready`, write `mem[ptr]`=`load_data`, then ptr++ and `loaded_words`++.
  - If `load_last` is set, or ptr==DEPTH-1, the next state is CHECK when the macro is defined, otherwise RUN.
  - The pointer never wraps. Filling the array ends the load even without `load_last`.
- Words not written in a load keep their previous contents. After reset, they read as `NOP_WORD`.
- RUN: the array is read-only and `load_ready`=0. `load_valid` is ignored.
- `reload` in any state takes effect on the next edge:
  - state → LOAD, ptr=0, `loaded_words`=0, `err`=0.
  - Array contents are kept.
  - `reload` wins over a same-cycle handshake. That word is not written.
- `fetch_inst` is a combinational read of the array. Reading a word in the same cycle it is written returns the old value.

## Timing
- Fetch read latency: 0 cycles (combinational), matching the fetch stage's single-cycle PC→instruction path.
- Last word accepted at edge N: `fetch_stall` falls after edge N (macro off), or after edge N+1 at the earliest (macro on, checksum beat accepted at N+1).
- `reload` sampled at edge N: `fetch_stall` is 1 after edge N.
- Asynchronous `rst` mid-load:
  - Forces LOAD immediately and re-fills the array with `NOP_WORD`.
  - Outputs then read `fetch_stall`=1, `load_ready`=1, `err`=0, `loaded_words`=0.

## Configuration
- `IMEM_LOAD_CHECKSUM_EN` defined:
  - After the last word, state CHECK accepts exactly one extra beat: the expected 32-bit checksum.
  - Checksum = sum of all written words of this load, modulo 2^32, kept in a running accumulator that is cleared on entry to LOAD.
  - Match: next state RUN.
  - Mismatch: next state ERR with `err`=1 and `fetch_stall` held at 1 until `reload` or `rst`.
  - `load_last` is ignored on the checksum beat.
- Not defined: no CHECK/ERR states, no accumulator, `err` tied 0, and the transition goes LOAD→RUN directly.

## Structure
- Package `imem_pkg`:
  - state enum.
  - `NOP_WORD` default constant.
  - `IMEM_ADDR_W(DEPTH)` helper (clog2).
- Sub-module `imem_array`: DEPTH×32 register array with one synchronous write port, one combinational read port and async reset fill. The FSM, pointer and checksum live in `imem_loader`.

## Test plan
- Reset, then stream 3 words 0xE3A00014, 0xE3A01A01, 0xE3A02103 with `load_last` on the third: `loaded_words`=3 and `fetch_stall` drops. Reads: `fetch_addr`=0→0xE3A00014, `fetch_addr`=8→0xE3A02103, `fetch_addr`=12→0xE0000000.
- Stream DEPTH words with no `load_last`: the block enters RUN after word DEPTH-1 and `load_ready`=0. `fetch_addr`=DEPTH*4 → 0xE0000000.
- Pulse `reload` in RUN, then load 1 word 0x1 with `load_last`: `fetch_addr`=0→0x1, and word 1 keeps its previously loaded value.
- Assert `reload` and a handshake in the same cycle with data 0xDEAD: no write occurs, ptr=0, `fetch_stall`=1.
- With the macro: words 1, 2, 3 and then checksum 6 → RUN with `err`=0. Words 1, 2, 3 and then checksum 7 → `err`=1 and `fetch_stall` stays 1 until `reload`.
- Assert `rst` after 2 of 5 words: all reads return 0xE0000000, `loaded_words`=0, `load_ready`=1.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader slice.
// The checksum feature is enabled with the IMEM_LOAD_CHECKSUM_EN macro.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERR   = 2'd3
  } imem_state_e;

  // AL-condition AND R0,R0,R0: harmless if the fetch stage runs off the end
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'hE000_0000;

  function automatic int IMEM_ADDR_W(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction RAM: one synchronous write port, one combinational
// read port, and an asynchronous reset that fills every word with NOP_WORD.
module imem_array
  import imem_pkg::*;
#(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD,
  localparam int         AW       = IMEM_ADDR_W(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NOP_WORD;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read-before-write: a same-cycle write becomes visible after the edge
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Fills the instruction RAM from a boot word stream, stalls fetch until the
// program is complete, then serves PC-indexed reads. Macro: IMEM_LOAD_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD,
  localparam int         AW       = IMEM_ADDR_W(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reload_i,
  input  logic        load_valid_i,
  output logic        load_ready_o,
  input  logic [31:0] load_data_i,
  input  logic        load_last_i,
  input  logic [31:0] fetch_addr_i,
  output logic [31:0] fetch_inst_o,
  output logic        fetch_stall_o,
  output logic [AW:0] loaded_words_o,
  output logic        err_o
);

  imem_state_e state_q, state_d;
  // The word count doubles as the write pointer; it never exceeds DEPTH
  logic [AW:0] count_q, count_d;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        fetch_in_range;

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      count_q <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mem_we  = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    // Reload pre-empts everything, including a handshake in the same cycle
    if (reload_i) begin
      state_d = ST_LOAD;
      count_d = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_d   = '0;
`endif
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (load_valid_i) begin
            mem_we  = 1'b1;
            count_d = count_q + 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_d   = sum_q + load_data_i;
`endif
            if (load_last_i || (count_q == (AW+1)'(DEPTH - 1))) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
              state_d = ST_CHECK;
`else
              state_d = ST_RUN;
`endif
            end
          end
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        ST_CHECK: begin
          if (load_valid_i) begin
            state_d = (load_data_i == sum_q) ? ST_RUN : ST_ERR;
          end
        end
`endif
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  imem_array #(
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP_WORD)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (load_data_i),
    .raddr_i (fetch_addr_i[AW+1:2]),
    .rdata_o (mem_rdata)
  );

  assign fetch_in_range = (fetch_addr_i < 32'(DEPTH * 4));
  assign fetch_inst_o   = fetch_in_range ? mem_rdata : NOP_WORD;
  assign fetch_stall_o  = (state_q != ST_RUN);
  assign load_ready_o   = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign loaded_words_o = count_q;

`ifdef IMEM_LOAD_CHECKSUM_EN
  assign err_o = (state_q == ST_ERR);
`else
  assign err_o = 1'b0;
`endif

endmodule
